ram_stream_reader: RTL and testbench

Read-side initiator for the single-port-style `ram` block. It takes a descriptor (base address, stride, word count), issues `read_req`/`read_addr` to the RAM, and absorbs the RAM's fixed 1-cycle read latency. Returned words are delivered as a valid/ready stream with a last-word marker. It sits between the RAM and downstream SIMD lane consumers, and sustains one word per cycle when the consumer does not stall.

---
 rtl/ram_stream_reader_if.sv | 33 +++
 rtl/ram_stream_reader.sv | 147 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// Descriptor, RAM read port and output stream of the RAM stream reader.
// The reader binds to master; the RAM and consumer side binds to slave.
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [ADDR_WIDTH-1:0]  stride;
    logic [COUNT_WIDTH-1:0] num_words;
    logic                   busy;
    logic                   done;

    logic                   mem_read_req;
    logic [ADDR_WIDTH-1:0]  mem_read_addr;
    logic [DATA_WIDTH-1:0]  mem_read_data;

    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_last;
    logic                   out_ready;

    modport master (
        input  start, base_addr, stride, num_words, mem_read_data, out_ready,
        output busy, done, mem_read_req, mem_read_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, base_addr, stride, num_words, mem_read_data, out_ready,
        input  busy, done, mem_read_req, mem_read_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Strided RAM reader: issues reads for a descriptor, absorbs the 1-cycle read
// latency and delivers words as a valid/ready stream with a last marker.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a start strobe
//   RUN   | reads still to be issued
//   DRAIN | all reads issued, waiting for the final handshake
//   DONE  | one-cycle completion pulse, back to IDLE next
module ram_stream_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset,
    ram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [ADDR_WIDTH-1:0]  stride_q;
    logic [COUNT_WIDTH-1:0] issue_rem;
    logic [COUNT_WIDTH-1:0] deliver_rem;
    logic                   inflight;
    logic                   busy_q;
    logic                   done_q;

    logic [DATA_WIDTH-1:0]  fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             fifo_count;

    logic                   out_valid;
    logic                   pop;
    logic                   bypass;
    logic                   push;
    logic                   fifo_pop;
    logic                   issue;
    logic [2:0]             occupancy;
    logic [DATA_WIDTH-1:0]  head;

    // The returning word is presented in the same cycle it arrives, so an
    // empty FIFO passes it straight through instead of costing a cycle.
    assign out_valid = (fifo_count != 2'd0) || inflight;
    assign pop       = out_valid && bus.out_ready;
    assign bypass    = pop && (fifo_count == 2'd0);
    assign push      = inflight && !bypass;
    assign fifo_pop  = pop && (fifo_count != 2'd0);

    // pop implies a stored or arriving word, so this never underflows
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == RUN) && (issue_rem != '0) && (occupancy <= 3'd1);

    always_comb begin
        head = '0;
        if (fifo_count != 2'd0) begin
            head = fifo_mem[rd_ptr];
        end else if (inflight) begin
            head = bus.mem_read_data;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.mem_read_req  = issue;
    assign bus.mem_read_addr = addr;
    assign bus.out_valid     = out_valid;
    assign bus.out_data      = head;
    assign bus.out_last      = out_valid && (deliver_rem == COUNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            stride_q    <= '0;
            issue_rem   <= '0;
            deliver_rem <= '0;
            inflight    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight <= issue;
            done_q   <= 1'b0;

            if (issue) begin
                addr      <= addr + stride_q;
                issue_rem <= issue_rem - COUNT_WIDTH'(1);
            end
            if (pop) begin
                deliver_rem <= deliver_rem - COUNT_WIDTH'(1);
            end

            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, fifo_pop};

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr        <= bus.base_addr;
                        stride_q    <= bus.stride;
                        issue_rem   <= bus.num_words;
                        deliver_rem <= bus.num_words;
                        if (bus.num_words == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (issue_rem == COUNT_WIDTH'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (deliver_rem == COUNT_WIDTH'(1))) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage has no reset; out_data is masked to zero while nothing is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_read_data;
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a RAM model answers reads, jobs push
// expected addresses and words, and a negedge monitor checks the DUT against them.
module tb_ram_stream_reader;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:65535];
    logic [15:0] exp_addr [$];
    logic [16:0] exp_word [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_valid, valid_cnt, last_hs, done_cnt;
    int issued, delivered;
    bit stall;
    logic [15:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: 1-cycle read latency, all-ones after reset, garbage when idle
    always @(posedge clk) begin
        if (reset) bus.mem_read_data <= '1;
        else if (bus.mem_read_req) bus.mem_read_data <= mem[bus.mem_read_addr];
        else bus.mem_read_data <= 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_for(input int mode, input int i);
        logic [5:0] pat = 6'b101001;
        case (mode)
            0: return 1'b1;
            1: return pat[i % 6];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    always @(negedge clk) begin
        logic pop;
        logic [16:0] w;
        logic [15:0] a;
        if (reset) begin
            issued = 0;
            delivered = 0;
            stall = 0;
        end else begin
            pop = bus.out_valid && bus.out_ready;
            if (stall) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_data", bus.out_data, held);
            end
            if (bus.mem_read_req) begin
                chk("occupancy_at_issue", (issued - delivered - int'(pop)) <= 1, 1'b1);
                if (exp_addr.size() == 0) chk("req_unexpected", bus.mem_read_req, 1'b0);
                else begin
                    a = exp_addr.pop_front();
                    chk("read_addr", bus.mem_read_addr, a);
                end
            end
            if (bus.out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (pop) begin
                if (exp_word.size() == 0) chk("word_unexpected", pop, 1'b0);
                else begin
                    w = exp_word.pop_front();
                    chk("out_data", bus.out_data, w[15:0]);
                    chk("out_last", bus.out_last, w[16]);
                    if (w[16]) last_hs = cyc;
                end
            end
            if (bus.done) done_cnt++;
            issued += int'(bus.mem_read_req);
            delivered += int'(pop);
            stall = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
        end
    end

    task automatic run_job(input logic [15:0] b, input logic [15:0] s, input logic [15:0] n,
                           input int mode, input bit poke);
        int ts, done_at;
        bit done_seen;
        logic [15:0] a;
        for (int k = 0; k < int'(n); k++) begin
            a = b + 16'(k) * s;
            exp_addr.push_back(a);
            exp_word.push_back({k == int'(n) - 1, mem[a]});
        end
        first_valid = -1;
        valid_cnt = 0;
        last_hs = -1;
        bus.base_addr = b;
        bus.stride = s;
        bus.num_words = n;
        bus.start = 1'b1;
        bus.out_ready = ready_for(mode, 0);
        step();
        bus.start = 1'b0;
        bus.base_addr = 16'($urandom);
        bus.stride = 16'($urandom);
        bus.num_words = 16'($urandom);
        @(negedge clk);
        ts = cyc;
        chk("busy_after_start", bus.busy, n != 0);
        chk("req_after_start", bus.mem_read_req, n != 0);
        done_seen = bus.done;
        done_at = ts;
        for (int i = 1; i < 400 && !done_seen; i++) begin
            step();
            bus.out_ready = ready_for(mode, i);
            if (poke && i == 2) begin
                bus.start = 1'b1;
                bus.base_addr = 16'h1234;
                bus.stride = 16'd7;
                bus.num_words = 16'd3;
            end
            if (poke && i == 3) bus.start = 1'b0;
            @(negedge clk);
            if (bus.done) begin
                done_seen = 1'b1;
                done_at = cyc;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", done_seen, 1'b1);
        chk("busy_at_done", bus.busy, 1'b0);
        if (n == 0) begin
            chk("zero_done_cycle", done_at, ts);
            chk("zero_no_valid", valid_cnt, 0);
        end else begin
            chk("done_after_last", done_at, last_hs + 1);
            if (mode == 0) begin
                chk("first_valid", first_valid, ts + 1);
                chk("last_handshake", last_hs, ts + int'(n));
                chk("valid_cycles", valid_cnt, int'(n));
            end
        end
        chk("words_left", exp_word.size(), 0);
        chk("addrs_left", exp_addr.size(), 0);
        step();
        @(negedge clk);
        chk("done_pulse_width", bus.done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int dc;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.stride = '0;
        bus.num_words = '0;
        bus.out_ready = 1'b1;
        done_cnt = 0;
        first_valid = -1;
        valid_cnt = 0;
        last_hs = -1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i + 'h100);

        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_req", bus.mem_read_req, 1'b0);
        chk("rst_addr", bus.mem_read_addr, 16'h0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 16'h0);
        chk("rst_last", bus.out_last, 1'b0);
        step();
        reset = 1'b0;
        step();

        run_job(16'h0010, 16'd1, 16'd8, 0, 1'b0);
        run_job(16'hFFFE, 16'd3, 16'd4, 0, 1'b0);
        run_job(16'h0040, 16'd5, 16'd6, 1, 1'b0);
        run_job(16'h0050, 16'd1, 16'd0, 0, 1'b0);
        run_job(16'h0060, 16'd2, 16'd5, 0, 1'b1);

        // abort a 10-word job three cycles in
        for (int k = 0; k < 10; k++) begin
            exp_addr.push_back(16'(16'h0200 + 2 * k));
            exp_word.push_back({k == 9, mem[16'h0200 + 2 * k]});
        end
        dc = done_cnt;
        bus.base_addr = 16'h0200;
        bus.stride = 16'd2;
        bus.num_words = 16'd10;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_req", bus.mem_read_req, 1'b0);
        chk("abort_addr", bus.mem_read_addr, 16'h0);
        chk("abort_valid", bus.out_valid, 1'b0);
        chk("abort_data", bus.out_data, 16'h0);
        chk("abort_last", bus.out_last, 1'b0);
        exp_addr.delete();
        exp_word.delete();
        repeat (6) step();
        chk("abort_no_done", done_cnt, dc);
        run_job(16'h0300, 16'd5, 16'd2, 0, 1'b0);

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int j = 0; j < 14; j++) begin
            run_job(16'($urandom), 16'($urandom), 16'($urandom_range(0, 12)),
                    (j % 3 == 0) ? 0 : 2, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
